// File: rtl/classify_pipe1_ctrl.sv
// Pipe-1 classification sequencer: loads K centroid registers, then streams N points from the point RAM into the input register.
// Latency: centroid/state outputs come from flops; a pass takes K+N+2 cycles from the start cycle to done, plus any stalled cycles.
// Backpressure: stall freezes new reads and input-register loads in STREAM/DRAIN; a fetched point is held pending until stall drops.
//
// Ports: clk/rst_n (sync, active-low); start/reload_centroids/num_centroids/num_points sampled in IDLE;
//   stall from pipe 2; cent_idx/centroid_en drive centroid loading; ram_rd_en/ram_addr read the point RAM;
//   input_reg_en/dist_valid qualify the datapath; busy/done/points_issued report pass status.
// Optional: define CLASSIFY_CTRL_PERF_EN to add the 16-bit saturating stall_cycles counter output.
module classify_pipe1_ctrl #(
  parameter int addrWidth      = 8,
  parameter int centroid_num   = 8,
  parameter int cent_idx_width = 3,
  parameter int cnt_width      = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      reload_centroids,
  input  logic [cent_idx_width:0]   num_centroids,
  input  logic [cnt_width-1:0]      num_points,
  input  logic                      stall,
  output logic [cent_idx_width-1:0] cent_idx,
  output logic [centroid_num-1:0]   centroid_en,
  output logic                      ram_rd_en,
  output logic [addrWidth-1:0]      ram_addr,
  output logic                      input_reg_en,
  output logic                      dist_valid,
  output logic                      busy,
  output logic                      done,
  output logic [cnt_width-1:0]      points_issued
`ifdef CLASSIFY_CTRL_PERF_EN
  ,
  output logic [15:0]               stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD_CENT, STREAM, DRAIN, DONE} state_t;

  localparam logic [cent_idx_width:0] K_MAX = (cent_idx_width+1)'(centroid_num);

  state_t                    state, state_d;
  logic [cent_idx_width-1:0] cent_i;
  logic [cent_idx_width:0]   k_reg;
  logic [cent_idx_width:0]   k_eff;
  logic [cent_idx_width:0]   cent_i_p1;
  logic [cnt_width-1:0]      n_reg;
  logic [cnt_width-1:0]      rd_idx;
  logic                      pending;
  logic                      start_acc;
  logic                      rd_fire;
  logic                      ire;
  logic                      last_rd;
  logic                      last_cent;

  // Out-of-range K falls back to loading every centroid register.
  assign k_eff     = (num_centroids == '0 || num_centroids > K_MAX) ? K_MAX : num_centroids;
  assign start_acc = (state == IDLE) && start;
  assign cent_i_p1 = {1'b0, cent_i} + (cent_idx_width+1)'(1);
  assign last_cent = (cent_i_p1 == k_reg);
  assign last_rd   = ((rd_idx + cnt_width'(1)) == n_reg);

  // Reads remain whenever we are in STREAM: the last read moves us to DRAIN.
  assign rd_fire = (state == STREAM) && !stall;
  // A pending point loads as soon as pipe 2 is not stalling, possibly alongside the next read.
  assign ire     = (state == STREAM || state == DRAIN) && pending && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (reload_centroids)       state_d = LOAD_CENT;
          else if (num_points == '0)  state_d = DONE;
          else                        state_d = STREAM;
        end
      end
      LOAD_CENT: begin
        if (last_cent) state_d = (n_reg == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (rd_fire && last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (ire) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cent_i        <= '0;
      k_reg         <= '0;
      n_reg         <= '0;
      rd_idx        <= '0;
      pending       <= 1'b0;
      points_issued <= '0;
      dist_valid    <= 1'b0;
    end else begin
      dist_valid <= ire;
      if (start_acc) begin
        cent_i        <= '0;
        k_reg         <= k_eff;
        n_reg         <= num_points;
        rd_idx        <= '0;
        pending       <= 1'b0;
        points_issued <= '0;
      end else begin
        if (state == LOAD_CENT && !last_cent) cent_i <= cent_i + cent_idx_width'(1);
        if (rd_fire) rd_idx <= rd_idx + cnt_width'(1);
        if (rd_fire)  pending <= 1'b1;
        else if (ire) pending <= 1'b0;
        if (ire) points_issued <= points_issued + cnt_width'(1);
      end
    end
  end

`ifdef CLASSIFY_CTRL_PERF_EN
  // Counts cycles where stall blocks a read (STREAM) or a pending load (DRAIN).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if (stall && (state == STREAM || (state == DRAIN && pending)) &&
                 stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign cent_idx     = (state == LOAD_CENT) ? cent_i : '0;
  assign centroid_en  = (state == LOAD_CENT) ? (centroid_num'(1) << cent_i) : '0;
  assign ram_rd_en    = rd_fire;
  assign ram_addr     = (state == STREAM) ? rd_idx[addrWidth-1:0] : '0;
  assign input_reg_en = ire;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_classify_pipe1_ctrl.sv
module tb_classify_pipe1_ctrl;
  localparam int AW = 8, CN = 8, CIW = 3, CW = 9;

  logic           clk = 1'b0;
  logic           rst_n, start, reload_centroids, stall;
  logic [CIW:0]   num_centroids;
  logic [CW-1:0]  num_points;
  logic [CIW-1:0] cent_idx;
  logic [CN-1:0]  centroid_en;
  logic           ram_rd_en;
  logic [AW-1:0]  ram_addr;
  logic           input_reg_en, dist_valid, busy, done;
  logic [CW-1:0]  points_issued;
`ifdef CLASSIFY_CTRL_PERF_EN
  logic [15:0]    stall_cycles;
`endif

  classify_pipe1_ctrl #(.addrWidth(AW), .centroid_num(CN), .cent_idx_width(CIW), .cnt_width(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload_centroids(reload_centroids),
    .num_centroids(num_centroids), .num_points(num_points), .stall(stall),
    .cent_idx(cent_idx), .centroid_en(centroid_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .input_reg_en(input_reg_en), .dist_valid(dist_valid), .busy(busy), .done(done),
    .points_issued(points_issued)
`ifdef CLASSIFY_CTRL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int exp_cent[$], exp_addr[$], exp_done_cyc[$], exp_done_pts[$];
  bit mon_en = 1'b0;
  int ire_cnt = 0, dv_cnt = 0, done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty expectation queue (cycle %0d)", name, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cent_idx"}, cent_idx, 0);
    check({tag, "_centroid_en"}, centroid_en, 0);
    check({tag, "_ram_rd_en"}, ram_rd_en, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_input_reg_en"}, input_reg_en, 0);
    check({tag, "_dist_valid"}, dist_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_points_issued"}, points_issued, 0);
  endtask

  // Monitor: samples on the falling edge, away from input changes and the active edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      if (done) done_seen++;
    end else begin
      if (centroid_en != '0) begin
        if (exp_cent.size() == 0) unexpected("centroid_en");
        else begin
          int e;
          e = exp_cent.pop_front();
          check("cent_idx", cent_idx, e);
          check("centroid_en", centroid_en, 1 << e);
        end
      end
      if (ram_rd_en) begin
        check("rd_under_stall", stall, 0);
        if (exp_addr.size() == 0) unexpected("ram_rd_en");
        else check("ram_addr", ram_addr, exp_addr.pop_front());
      end
      if (input_reg_en) begin
        check("ire_under_stall", stall, 0);
        ire_cnt++;
      end
      if (dist_valid) dv_cnt++;
      if (done) begin
        if (exp_done_cyc.size() == 0) unexpected("done");
        else begin
          int ec, ep;
          ec = exp_done_cyc.pop_front();
          ep = exp_done_pts.pop_front();
          check("done_cycle", cyc, ec);
          check("points_issued", points_issued, ep);
          check("ire_pulses", ire_cnt, ep);
          check("dv_pulses", dv_cnt, ep);
          check("dv_with_done", dist_valid, (ep != 0) ? 1 : 0);
          check("busy_at_done", busy, 1);
        end
        ire_cnt = 0;
        dv_cnt  = 0;
      end
    end
  end

  // Pushes the expected response of a pass, then pulses start for one cycle.
  // Called at posedge+#1; returns at posedge+#1 one cycle after the start cycle.
  task automatic run_pass(input bit rl, input int k, input int n, input int extra);
    int keff, sc;
    keff = (k == 0 || k > CN) ? CN : k;
    sc = cyc;
    if (rl) for (int i = 0; i < keff; i++) exp_cent.push_back(i);
    for (int i = 0; i < n; i++) exp_addr.push_back(i % 256);
    if (!rl && n == 0) exp_done_cyc.push_back(sc + 1);
    else               exp_done_cyc.push_back(sc + (rl ? keff : 0) + n + 2 + extra);
    exp_done_pts.push_back(n);
    reload_centroids = rl;
    num_centroids    = 4'(k);
    num_points       = 9'(n);
    start            = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_done_cyc.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) unexpected("timeout_waiting_done");
    repeat (3) @(posedge clk);
    #1;
    check("leftover_cent", exp_cent.size(), 0);
    check("leftover_addr", exp_addr.size(), 0);
    check("idle_after_pass", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; reload_centroids = 1'b0; stall = 1'b0;
    num_centroids = '0; num_points = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Full load, no stall.
    run_pass(1'b1, 3, 4, 0);
    wait_drain();

    // Skip reload with N=0: done one cycle after start.
    run_pass(1'b0, 5, 0, 0);
    wait_drain();

    // Stall for 3 cycles right after the second read.
    run_pass(1'b1, 1, 5, 3);
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_drain();
`ifdef CLASSIFY_CTRL_PERF_EN
    check("stall_cycles", stall_cycles, 3);
`endif

    // Boundary: N=256 with all centroids, then K=0 clamps to 8.
    run_pass(1'b1, 8, 256, 0);
    wait_drain();
    run_pass(1'b1, 0, 2, 0);
    wait_drain();

    // Second start during STREAM is ignored.
    run_pass(1'b1, 2, 6, 0);
    repeat (3) @(posedge clk);
    #1;
    reload_centroids = 1'b0;
    num_points = 9'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // Reset mid-pass aborts without done.
    mon_en = 1'b0;
    done_seen = 0;
    reload_centroids = 1'b1;
    num_centroids = 4'd8;
    num_points = 9'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("done_after_abort", done_seen, 0);
    ire_cnt = 0;
    dv_cnt = 0;
    mon_en = 1'b1;

    // Recovery pass after the abort.
    run_pass(1'b0, 1, 3, 0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
